// File: rtl/d_phy_pkg.sv
// Shared constants and types for the D-PHY HS receive path.
package d_phy_pkg;

    localparam logic [7:0] HS_SYNC_BYTE              = 8'hB8;
    localparam int         HS_RX_WORD_BIT_WIDTH_DFLT = 16;
    localparam int         HS_SYNC_TIMEOUT_DFLT      = 64;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        SYNCED = 2'd2,
        ERR    = 2'd3
    } hs_rx_state_t;

    // Byte as it appears in a left-shifting register fed LSB-first:
    // the first bit on the wire ends up in the MSB.
    function automatic logic [7:0] arrival_order(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[7 - i] = b[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/d_phy_rx_sync_detect.sv
// HS sync byte hunter: 8-bit history plus a compare at both bit offsets of
// the incoming dibit.
module d_phy_rx_sync_detect
    import d_phy_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift_en,
    input  logic [1:0] dibit,
    output logic       match,
    output logic       phase_odd
);

    localparam logic [7:0] SYNC_PATTERN = arrival_order(HS_SYNC_BYTE);

    logic [7:0] sr_q;
    logic [7:0] sr_d;
    logic [7:0] win_bit0_s;
    logic [7:0] win_bit1_s;

    // Candidate windows ending on each bit of the dibit, and next history.
    always_comb begin
        win_bit0_s = {sr_q[6:0], dibit[0]};
        win_bit1_s = {sr_q[5:0], dibit[0], dibit[1]};
        phase_odd  = (win_bit0_s == SYNC_PATTERN);
        match      = shift_en && ((win_bit0_s == SYNC_PATTERN) || (win_bit1_s == SYNC_PATTERN));
        if (clear) begin
            sr_d = 8'hFF;
        end else if (shift_en) begin
            sr_d = win_bit1_s;
        end else begin
            sr_d = sr_q;
        end
    end

    // History register; all ones so a short burst can never fake a match.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= 8'hFF;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/d_phy_rx_word_aligner.sv
// HS receive word aligner: locks on the sync byte, deserializes the payload
// into W-bit words and regenerates the receive word clock.
module d_phy_rx_word_aligner
    import d_phy_pkg::*;
#(
    parameter int HS_RX_WORD_BIT_WIDTH = d_phy_pkg::HS_RX_WORD_BIT_WIDTH_DFLT,
    parameter int HS_SYNC_TIMEOUT      = d_phy_pkg::HS_SYNC_TIMEOUT_DFLT
) (
    input  logic                            hs_clk,
    input  logic                            rst,
    input  logic                            hs_rx_active,
    input  logic [1:0]                      hs_rx_dibit,
    output logic [HS_RX_WORD_BIT_WIDTH-1:0] hs_rx_word,
    output logic                            hs_rx_word_valid,
    output logic                            hs_rx_word_clk,
    output logic                            hs_rx_synced,
    output logic                            hs_rx_sync_err
);

    localparam int W       = HS_RX_WORD_BIT_WIDTH;
    localparam int HALF    = W / 2;
    localparam int QUARTER = W / 4;
    localparam int CNT_W   = $clog2(W + 1);
    localparam int WC_W    = $clog2(HALF + 1);
    localparam int HUNT_W  = $clog2(HS_SYNC_TIMEOUT + 1);

    hs_rx_state_t      state_q, state_d;
    logic [HUNT_W-1:0] hunt_cnt_q, hunt_cnt_d;
    logic [W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              phase_odd_q, phase_odd_d;
    logic [W-1:0]      word_q, word_d;
    logic              valid_q, valid_d;
    logic              synced_q, synced_d;
    logic              err_q, err_d;
    logic              wclk_q, wclk_d;
    logic              wclk_run_q, wclk_run_d;
    logic [WC_W-1:0]   wclk_cnt_q, wclk_cnt_d;

    logic              match_s;
    logic              phase_odd_s;

    d_phy_rx_sync_detect u_sync_detect (
        .clk       (hs_clk),
        .rst       (rst),
        .clear     (state_q != HUNT),
        .shift_en  (state_q == HUNT),
        .dibit     (hs_rx_dibit),
        .match     (match_s),
        .phase_odd (phase_odd_s)
    );

    // Next-state logic: FSM, payload accumulator and word-clock counter.
    always_comb begin
        state_d     = state_q;
        hunt_cnt_d  = hunt_cnt_q;
        acc_d       = acc_q;
        bit_cnt_d   = bit_cnt_q;
        phase_odd_d = phase_odd_q;
        word_d      = word_q;
        valid_d     = LOW;
        synced_d    = synced_q;
        err_d       = LOW;
        wclk_d      = wclk_q;
        wclk_run_d  = wclk_run_q;
        wclk_cnt_d  = wclk_cnt_q;

        if (!hs_rx_active) begin
            // Burst over: partial word dropped, last delivered word kept.
            state_d    = IDLE;
            hunt_cnt_d = HUNT_W'(0);
            bit_cnt_d  = CNT_W'(0);
            synced_d   = LOW;
            wclk_d     = LOW;
            wclk_run_d = LOW;
            wclk_cnt_d = WC_W'(0);
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = HUNT;
                    hunt_cnt_d = HUNT_W'(0);
                    bit_cnt_d  = CNT_W'(0);
                    synced_d   = LOW;
                end
                HUNT: begin
                    if (match_s) begin
                        state_d     = SYNCED;
                        synced_d    = HIGH;
                        phase_odd_d = phase_odd_s;
                        if (phase_odd_s) begin
                            // Falling-edge bit of this dibit is payload bit 0.
                            acc_d     = {hs_rx_dibit[1], acc_q[W-1:1]};
                            bit_cnt_d = CNT_W'(1);
                        end else begin
                            bit_cnt_d = CNT_W'(0);
                        end
                    end else if (hunt_cnt_q == HUNT_W'(HS_SYNC_TIMEOUT - 1)) begin
                        state_d = ERR;
                        err_d   = HIGH;
                    end else begin
                        hunt_cnt_d = hunt_cnt_q + HUNT_W'(1);
                    end
                end
                SYNCED: begin
                    synced_d = HIGH;
                    // Bits enter at the top and move down, so the first bit
                    // of a word lands in [0] once W bits are in.
                    if (bit_cnt_q >= CNT_W'(W - 2)) begin
                        valid_d = HIGH;
                        if (phase_odd_q) begin
                            word_d    = {hs_rx_dibit[0], acc_q[W-1:1]};
                            acc_d     = {hs_rx_dibit[1], acc_q[W-1:1]};
                            bit_cnt_d = CNT_W'(1);
                        end else begin
                            word_d    = {hs_rx_dibit[1], hs_rx_dibit[0], acc_q[W-1:2]};
                            bit_cnt_d = CNT_W'(0);
                        end
                    end else begin
                        acc_d     = {hs_rx_dibit[1], hs_rx_dibit[0], acc_q[W-1:2]};
                        bit_cnt_d = bit_cnt_q + CNT_W'(2);
                    end
                end
                ERR: begin
                    synced_d = LOW;
                end
                default: begin
                    state_d  = IDLE;
                    synced_d = LOW;
                end
            endcase

            // Word clock: rises with every word, W/4 high then W/4 low.
            if (valid_d) begin
                wclk_run_d = HIGH;
                wclk_cnt_d = WC_W'(0);
                wclk_d     = HIGH;
            end else if (wclk_run_q) begin
                if (wclk_cnt_q == WC_W'(HALF - 1)) begin
                    wclk_cnt_d = WC_W'(0);
                end else begin
                    wclk_cnt_d = wclk_cnt_q + WC_W'(1);
                end
                wclk_d = (wclk_cnt_d < WC_W'(QUARTER));
            end else begin
                wclk_d = LOW;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge hs_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hunt_cnt_q  <= HUNT_W'(0);
            acc_q       <= {W{1'b0}};
            bit_cnt_q   <= CNT_W'(0);
            phase_odd_q <= LOW;
            word_q      <= {W{1'b0}};
            valid_q     <= LOW;
            synced_q    <= LOW;
            err_q       <= LOW;
            wclk_q      <= LOW;
            wclk_run_q  <= LOW;
            wclk_cnt_q  <= WC_W'(0);
        end else begin
            state_q     <= state_d;
            hunt_cnt_q  <= hunt_cnt_d;
            acc_q       <= acc_d;
            bit_cnt_q   <= bit_cnt_d;
            phase_odd_q <= phase_odd_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            synced_q    <= synced_d;
            err_q       <= err_d;
            wclk_q      <= wclk_d;
            wclk_run_q  <= wclk_run_d;
            wclk_cnt_q  <= wclk_cnt_d;
        end
    end

    assign hs_rx_word       = word_q;
    assign hs_rx_word_valid = valid_q;
    assign hs_rx_word_clk   = wclk_q;
    assign hs_rx_synced     = synced_q;
    assign hs_rx_sync_err   = err_q;

endmodule

// File: tb/tb_d_phy_rx_word_aligner.sv
// Bench for d_phy_rx_word_aligner: three instances (W=16, 8, 32) driven from
// a bit-stream builder; expected words go to per-instance queues.
module tb_d_phy_rx_word_aligner;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] act;
    logic [1:0] dib [3];
    wire [15:0] word16;
    wire [7:0]  word8;
    wire [31:0] word32;
    wire [2:0]  vld, wclk, syn, err;

    always #5 clk = ~clk;

    d_phy_rx_word_aligner #(.HS_RX_WORD_BIT_WIDTH(16), .HS_SYNC_TIMEOUT(64)) dut16 (
        .hs_clk(clk), .rst(rst), .hs_rx_active(act[0]), .hs_rx_dibit(dib[0]),
        .hs_rx_word(word16), .hs_rx_word_valid(vld[0]), .hs_rx_word_clk(wclk[0]),
        .hs_rx_synced(syn[0]), .hs_rx_sync_err(err[0]));
    d_phy_rx_word_aligner #(.HS_RX_WORD_BIT_WIDTH(8), .HS_SYNC_TIMEOUT(64)) dut8 (
        .hs_clk(clk), .rst(rst), .hs_rx_active(act[1]), .hs_rx_dibit(dib[1]),
        .hs_rx_word(word8), .hs_rx_word_valid(vld[1]), .hs_rx_word_clk(wclk[1]),
        .hs_rx_synced(syn[1]), .hs_rx_sync_err(err[1]));
    d_phy_rx_word_aligner #(.HS_RX_WORD_BIT_WIDTH(32), .HS_SYNC_TIMEOUT(64)) dut32 (
        .hs_clk(clk), .rst(rst), .hs_rx_active(act[2]), .hs_rx_dibit(dib[2]),
        .hs_rx_word(word32), .hs_rx_word_valid(vld[2]), .hs_rx_word_clk(wclk[2]),
        .hs_rx_synced(syn[2]), .hs_rx_sync_err(err[2]));

    typedef struct {
        int          idx;
        int          zeros;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t        vecs [8];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          since  [3];
    int          last_v [3];
    logic [31:0] last_word [3];
    logic        bitq [$];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    logic [31:0] exp2 [$];

    function automatic int wid(input int i);
        case (i)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] word_of(input int i);
        case (i)
            0:       return {16'h0000, word16};
            1:       return {24'h000000, word8};
            default: return word32;
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return exp0.size();
            1:       return exp1.size();
            default: return exp2.size();
        endcase
    endfunction

    task automatic push_exp(input int i, input logic [31:0] v);
        case (i)
            0:       exp0.push_back(v);
            1:       exp1.push_back(v);
            default: exp2.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int i, output bit ok, output logic [31:0] v);
        ok = (qsize(i) > 0);
        v  = 32'h0;
        if (ok) begin
            case (i)
                0:       v = exp0.pop_front();
                1:       v = exp1.pop_front();
                default: v = exp2.pop_front();
            endcase
        end
    endtask

    task automatic chk(input int i, input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, i, cyc, got, exp_v);
        end
    endtask

    // Pushes n bits of v onto the wire stream, LSB first.
    task automatic add_bits(input logic [31:0] v, input int n);
        for (int b = 0; b < n; b++) bitq.push_back(v[b]);
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic sample();
        bit          ok;
        logic [31:0] e;
        logic        exp_clk;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (vld[i]) begin
                pop_exp(i, ok, e);
                chk(i, "valid_expected", {31'h0, ok}, 32'h1);
                if (ok) begin
                    chk(i, "word", word_of(i), e);
                    last_word[i] = e;
                end
                if (last_v[i] >= 0) chk(i, "valid_spacing", cyc - last_v[i], wid(i) / 2);
                last_v[i] = cyc;
                since[i]  = 0;
            end else if (since[i] >= 0) begin
                since[i]++;
            end
            exp_clk = (since[i] >= 0) && ((since[i] % (wid(i) / 2)) < (wid(i) / 4));
            chk(i, "word_clk", {31'h0, wclk[i]}, {31'h0, exp_clk});
        end
    endtask

    // Sends the stream on instance i; lock_k is the dibit completing the
    // sync byte, rst_k the dibit on which reset is applied (-1 for none).
    task automatic play(input int i, input int lock_k, input int rst_k);
        int   n;
        logic b0, b1;
        n = (bitq.size() + 1) / 2;
        last_v[i] = -1;
        for (int k = 0; k < n; k++) begin
            b0 = bitq.pop_front();
            b1 = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
            act[i] = 1'b1;
            dib[i] = {b1, b0};
            if (k == rst_k) begin
                rst = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    since[j]     = -1;
                    last_word[j] = 32'h0;
                end
            end
            sample();
            if (k == rst_k) begin
                chk(i, "rst_synced", {31'h0, syn[i]}, 32'h0);
                chk(i, "rst_err", {31'h0, err[i]}, 32'h0);
                chk(i, "rst_valid", {31'h0, vld[i]}, 32'h0);
                chk(i, "rst_word", word_of(i), 32'h0);
                rst = 1'b0;
                break;
            end
            if (k == lock_k - 1) chk(i, "synced_before_lock", {31'h0, syn[i]}, 32'h0);
            if (k == lock_k)     chk(i, "synced_at_lock", {31'h0, syn[i]}, 32'h1);
        end
        bitq.delete();
        act[i]   = 1'b0;
        dib[i]   = 2'b00;
        since[i] = -1;
        sample();
        chk(i, "synced_dropped", {31'h0, syn[i]}, 32'h0);
        chk(i, "word_held", word_of(i), last_word[i]);
        sample();
        chk(i, "scoreboard_empty", qsize(i), 0);
    endtask

    task automatic apply_vec(input vec_t v);
        int lock_k;
        bitq.delete();
        add_bits(32'h0, v.zeros);
        add_bits({24'h0, 8'hB8}, 8);
        lock_k = (bitq.size() - 1) / 2;
        add_bits(v.w0, wid(v.idx));
        push_exp(v.idx, v.w0);
        add_bits(v.w1, wid(v.idx));
        push_exp(v.idx, v.w1);
        play(v.idx, lock_k, -1);
    endtask

    initial begin
        int          lock_k;
        int          rst_k;
        int          errs;
        int          err_cyc;

        vecs[0] = '{0, 20, 32'h0000A55A, 32'h00001234};
        vecs[1] = '{0, 21, 32'h0000A55A, 32'h00001234};
        vecs[2] = '{0, 20, 32'h000000B8, 32'h00001234};
        vecs[3] = '{0, 23, 32'h000000B8, 32'h0000C3E1};
        vecs[4] = '{1, 20, 32'h000000A5, 32'h0000005A};
        vecs[5] = '{1, 21, 32'h00000012, 32'h000000B8};
        vecs[6] = '{2, 20, 32'hA55A1234, 32'hDEADBEEF};
        vecs[7] = '{2, 21, 32'h0F1E2D3C, 32'h80000001};

        rst = 1'b1;
        act = 3'b000;
        for (int j = 0; j < 3; j++) begin
            dib[j]       = 2'b00;
            since[j]     = -1;
            last_v[j]    = -1;
            last_word[j] = 32'h0;
        end
        repeat (3) sample();
        for (int j = 0; j < 3; j++) begin
            chk(j, "reset_synced", {31'h0, syn[j]}, 32'h0);
            chk(j, "reset_err", {31'h0, err[j]}, 32'h0);
            chk(j, "reset_valid", {31'h0, vld[j]}, 32'h0);
            chk(j, "reset_word", word_of(j), 32'h0);
        end
        rst = 1'b0;
        sample();

        for (int v = 0; v < 8; v++) apply_vec(vecs[v]);

        // HUNT timeout: zeros only, one err pulse 64 HUNT cycles in.
        errs    = 0;
        err_cyc = -1;
        act[0]  = 1'b1;
        dib[0]  = 2'b00;
        for (int k = 0; k < 70; k++) begin
            sample();
            if (err[0]) begin
                errs++;
                if (err_cyc < 0) err_cyc = k;
            end
        end
        chk(0, "sync_err_cycle", err_cyc, 64);
        chk(0, "sync_err_pulses", errs, 1);
        chk(0, "synced_in_err", {31'h0, syn[0]}, 32'h0);
        // A sync byte while in ERR must not lock.
        bitq.delete();
        add_bits({24'h0, 8'hB8}, 8);
        add_bits(32'h0, 8);
        while (bitq.size() > 0) begin
            dib[0][0] = bitq.pop_front();
            dib[0][1] = bitq.pop_front();
            sample();
            if (err[0]) errs++;
        end
        chk(0, "err_state_no_lock", {31'h0, syn[0]}, 32'h0);
        act[0] = 1'b0;
        dib[0] = 2'b00;
        repeat (4) begin
            sample();
            if (err[0]) errs++;
        end
        chk(0, "sync_err_not_repeated", errs, 1);
        chk(0, "idle_after_err", {31'h0, syn[0]}, 32'h0);

        // Burst dropped 11 bits into the second word.
        bitq.delete();
        add_bits(32'h0, 20);
        add_bits({24'h0, 8'hB8}, 8);
        lock_k = (bitq.size() - 1) / 2;
        add_bits(32'h0000A55A, 16);
        push_exp(0, 32'h0000A55A);
        add_bits(32'h00001234, 11);
        play(0, lock_k, -1);

        // Clean relock on a fresh burst.
        apply_vec(vecs[1]);

        // Reset on the dibit that would complete the second word.
        bitq.delete();
        add_bits(32'h0, 21);
        add_bits({24'h0, 8'hB8}, 8);
        lock_k = (bitq.size() - 1) / 2;
        add_bits(32'h0000A55A, 16);
        push_exp(0, 32'h0000A55A);
        add_bits(32'h00001234, 16);
        rst_k = (bitq.size() - 1) / 2;
        play(0, lock_k, rst_k);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
